// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types, instruction field positions and helpers
package cpu_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Instruction field positions used by the decoder and the PC logic
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int JIDX_MSB   = 25;
  localparam int JIDX_LSB   = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  // Sign-extended 16-bit branch immediate scaled to a byte offset
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - instruction-memory request/response bus with master/slave views
interface fetch_pc_unit_if;
  import cpu_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [31:0]        imem_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;

  // Fetch unit side: issues requests, receives instruction words
  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  // Memory side: accepts requests, returns instruction words
  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// rtl/fetch_pc_unit_next_pc_calc.sv - combinational branch/jump target and next-PC select (taken flag under PERF_CNT_EN)
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  logic        jump,
  input  logic        beq,
  input  logic        bne,
  input  logic        alu_zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
`ifdef PERF_CNT_EN
  ,
  output logic        taken
`endif
);

  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        br_taken;

  // Targets and priority select: jump, then conditional branch, then fall-through.
  // beq and bne together is not a legal decode and falls through.
  always_comb begin
    pc_plus4  = pc + 32'd4;
    br_target = pc_plus4 + branch_offset(instr_idx[IMM_MSB:IMM_LSB]);
    j_target  = {pc_plus4[31:28], instr_idx[JIDX_MSB:JIDX_LSB], 2'b00};
    br_taken  = (beq & ~bne & alu_zero) | (bne & ~beq & ~alu_zero);
    if (jump) begin
      next_pc = j_target;
    end else if (br_taken) begin
      next_pc = br_target;
    end else begin
      next_pc = pc_plus4;
    end
  end

`ifdef PERF_CNT_EN
  assign taken = jump | br_taken;
`endif

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC holder and single-outstanding instruction fetch sequencer (optional PERF_CNT_EN counters)
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_pc_unit_if.master      imem,
  output logic [INSTR_W-1:0]   instr_o,
  output logic                 instr_valid,
  output logic [ADDR_W-1:0]    pc_o,
  output logic [ADDR_W-1:0]    pc_plus4_o,
  input  logic                 exec_done,
  input  logic                 jump,
  input  logic                 beq,
  input  logic                 bne,
  input  logic                 alu_zero
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]          perf_retired,
  output logic [31:0]          perf_taken
`endif
);

  fetch_state_e       state;
  fetch_state_e       state_n;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  next_pc;
  logic               req_valid;
  logic               hold;
  logic               retire;
`ifdef PERF_CNT_EN
  logic               taken;
`endif

  next_pc_calc u_next_pc_calc (
    .pc        (pc_q),
    .instr_idx (instr_q[JIDX_MSB:JIDX_LSB]),
    .jump      (jump),
    .beq       (beq),
    .bne       (bne),
    .alu_zero  (alu_zero),
    .pc_plus4  (pc_plus4_o),
    .next_pc   (next_pc)
`ifdef PERF_CNT_EN
    ,
    .taken     (taken)
`endif
  );

  // An instruction retires only when execute completes while it is held
  assign retire = (state == HOLD) & exec_done;

  // State, PC and held instruction; reset wins over everything, including a retire
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= NOP_INSTR;
    end else begin
      state <= state_n;
      if ((state == WAIT) && imem.imem_rsp_valid) begin
        instr_q <= imem.imem_rsp_data;
      end
      if (retire) begin
        pc_q <= {next_pc[31:2], 2'b00};
      end
    end
  end

  // Next-state and handshake outputs; responses outside WAIT are dropped
  always_comb begin
    state_n   = state;
    req_valid = 1'b0;
    hold      = 1'b0;
    case (state)
      IDLE: begin
        state_n = REQ;
      end
      REQ: begin
        req_valid = 1'b1;
        if (imem.imem_req_ready) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rsp_valid) begin
          state_n = HOLD;
        end
      end
      HOLD: begin
        hold = 1'b1;
        if (exec_done) begin
          state_n = REQ;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Address comes straight from the PC register, so it cannot move while a request is pending
  assign imem.imem_req_valid = req_valid;
  assign imem.imem_addr      = pc_q;
  assign instr_o             = instr_q;
  assign instr_valid         = hold;
  assign pc_o                = pc_q;

`ifdef PERF_CNT_EN
  // Retired and taken-control-transfer counters, free-running with silent wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retired <= 32'd0;
      perf_taken   <= 32'd0;
    end else if (retire) begin
      perf_retired <= perf_retired + 32'd1;
      if (taken) begin
        perf_taken <= perf_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit (PERF_CNT_EN aware)
module tb_fetch_pc_unit;
  import cpu_pkg::*;

  typedef struct {
    logic [31:0] ins;
    logic        j;
    logic        bq;
    logic        bn;
    logic        z;
    logic [31:0] nxt;
    logic        tk;
  } vec_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, exec_done, jump, beq, bne, alu_zero;
  logic [31:0] instr_o, pc_o, pc_plus4_o;
  logic        instr_valid;
  logic        reset2, exec_done2, jump2, beq2, bne2, alu_zero2;
  logic [31:0] instr_o2, pc_o2, pc_plus4_o2;
  logic        instr_valid2;
`ifdef PERF_CNT_EN
  logic [31:0] perf_retired, perf_taken, perf_retired2, perf_taken2;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_q2[$];
  vec_t        v[15];

  fetch_pc_unit_if bus();
  fetch_pc_unit_if bus2();

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .imem(bus),
    .instr_o(instr_o), .instr_valid(instr_valid), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .exec_done(exec_done), .jump(jump), .beq(beq), .bne(bne), .alu_zero(alu_zero)
`ifdef PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_taken(perf_taken)
`endif
  );

  fetch_pc_unit #(.RESET_PC(32'h4000_0000), .ADDR_W(32)) dut2 (
    .clk(clk), .reset(reset2), .imem(bus2),
    .instr_o(instr_o2), .instr_valid(instr_valid2), .pc_o(pc_o2), .pc_plus4_o(pc_plus4_o2),
    .exec_done(exec_done2), .jump(jump2), .beq(beq2), .bne(bne2), .alu_zero(alu_zero2)
`ifdef PERF_CNT_EN
    , .perf_retired(perf_retired2), .perf_taken(perf_taken2)
`endif
  );

  // Second instance sees an always-ready memory returning "j 0x100" every cycle
  assign bus2.imem_req_ready = 1'b1;
  assign bus2.imem_rsp_valid = 1'b1;
  assign bus2.imem_rsp_data  = 32'h0800_0100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One fetch: wait for request, stall ready, accept, delay response, deliver word
  task automatic do_fetch(input logic [31:0] ins, input int rdly, input int sdly, output int cyc);
    int          n;
    logic [31:0] a;
    n = 0;
    while (bus.imem_req_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: request with no expected address, got %h", bus.imem_addr);
      a = bus.imem_addr;
    end else begin
      a = exp_q.pop_front();
      check("imem_addr", bus.imem_addr, a);
    end
    for (int i = 0; i < rdly; i++) begin
      exec_done = 1'b1;
      jump      = 1'b1;
      @(negedge clk);
      n++;
      check("addr_stable", bus.imem_addr, a);
      check("req_held", {31'd0, bus.imem_req_valid}, 32'd1);
    end
    exec_done = 1'b0;
    jump      = 1'b0;
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    n++;
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < sdly; i++) begin
      exec_done = 1'b1;
      jump      = 1'b1;
      @(negedge clk);
      n++;
      check("wait_no_valid", {31'd0, instr_valid}, 32'd0);
    end
    exec_done = 1'b0;
    jump      = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = ins;
    @(negedge clk);
    n++;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    check("instr_valid", {31'd0, instr_valid}, 32'd1);
    check("instr_o", instr_o, ins);
    cyc = n;
  endtask

  // Retire the held instruction with the given decode and queue the expected next address
  task automatic do_exec(input logic j, input logic bq, input logic bn, input logic z,
                         input logic [31:0] cur, input logic [31:0] nxt);
    check("pc_o", pc_o, cur);
    check("pc_plus4_o", pc_plus4_o, cur + 32'd4);
    jump = j; beq = bq; bne = bn; alu_zero = z;
    exec_done = 1'b1;
    exp_q.push_back(nxt);
    @(negedge clk);
    exec_done = 1'b0; jump = 1'b0; beq = 1'b0; bne = 1'b0; alu_zero = 1'b0;
    check("instr_valid_drop", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          n;
    int          ntk;
    logic [31:0] cur;

    v[0]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b0};
    v[1]  = '{32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1};
    v[2]  = '{32'h1000_0003, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 1'b1};
    v[3]  = '{32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1};
    v[4]  = '{32'h1000_0003, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0014, 1'b0};
    v[5]  = '{32'h0800_0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b1};
    v[6]  = '{32'h1400_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_003C, 1'b1};
    v[7]  = '{32'h1000_0005, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0};
    v[8]  = '{32'h1400_0010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0044, 1'b0};
    v[9]  = '{32'h1000_0010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0048, 1'b0};
    v[10] = '{32'h0800_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
    v[11] = '{32'h1400_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1};
    v[12] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    v[13] = '{32'h0BFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0FFF_FFFC, 1'b1};
    v[14] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0000, 1'b0};

    reset = 1'b1; exec_done = 1'b0; jump = 1'b0; beq = 1'b0; bne = 1'b0; alu_zero = 1'b0;
    reset2 = 1'b1; exec_done2 = 1'b0; jump2 = 1'b0; beq2 = 1'b0; bne2 = 1'b0; alu_zero2 = 1'b0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);

    check("rst_pc", pc_o, 32'h0000_0000);
    check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr_o", instr_o, 32'h0000_0000);
`ifdef PERF_CNT_EN
    check("rst_perf_retired", perf_retired, 32'd0);
    check("rst_perf_taken", perf_taken, 32'd0);
`endif

    exp_q.push_back(32'h0000_0000);
    reset = 1'b0;
    cur = 32'h0000_0000;
    ntk = 0;
    for (int i = 0; i < 15; i++) begin
      do_fetch(v[i].ins, i % 3, i % 2, cyc);
      if (i == 0) check("first_latency", cyc, 32'd3);
      do_exec(v[i].j, v[i].bq, v[i].bn, v[i].z, cur, v[i].nxt);
      cur = v[i].nxt;
      if (v[i].tk) ntk++;
    end
`ifdef PERF_CNT_EN
    check("perf_retired", perf_retired, 32'd15);
    check("perf_taken", perf_taken, ntk);
`endif

    // Stalled handshake, then a spurious response while holding
    do_fetch(32'h1000_0007, 4, 5, cyc);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    check("spurious_instr_o", instr_o, 32'h1000_0007);
    check("spurious_valid", {31'd0, instr_valid}, 32'd1);
    do_exec(1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0000, 32'h1000_0004);

    // Reset beats a simultaneous retire
    do_fetch(32'h0800_0123, 0, 0, cyc);
    exec_done = 1'b1; jump = 1'b1; reset = 1'b1;
    @(negedge clk);
    exec_done = 1'b0; jump = 1'b0; reset = 1'b0;
    check("rstprio_pc", pc_o, 32'h0000_0000);
    check("rstprio_valid", {31'd0, instr_valid}, 32'd0);
    exp_q.delete();
    exp_q.push_back(32'h0000_0000);

    // Reset with a request outstanding, then a late response that must be dropped
    n = 0;
    while (bus.imem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wr_addr", bus.imem_addr, exp_q.pop_front());
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("wr_pc", pc_o, 32'h0000_0000);
    check("wr_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("wr_instr_valid", {31'd0, instr_valid}, 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hFEED_F00D;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    check("late_rsp_dropped", {31'd0, instr_valid}, 32'd0);
    check("late_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check("late_instr_o", instr_o, 32'h0000_0000);
    exp_q.push_back(32'h0000_0000);
    do_fetch(32'h0000_1111, 0, 0, cyc);
    do_exec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004);

    // Jump wins over a concurrent beq from a non-zero region
    reset2 = 1'b0;
    n = 0;
    while (instr_valid2 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("d2_instr_valid", {31'd0, instr_valid2}, 32'd1);
    check("d2_pc", pc_o2, 32'h4000_0000);
    check("d2_instr_o", instr_o2, 32'h0800_0100);
    jump2 = 1'b1; beq2 = 1'b1; alu_zero2 = 1'b1; exec_done2 = 1'b1;
    exp_q2.push_back(32'h4000_0400);
    @(negedge clk);
    jump2 = 1'b0; beq2 = 1'b0; alu_zero2 = 1'b0; exec_done2 = 1'b0;
    check("d2_req_valid", {31'd0, bus2.imem_req_valid}, 32'd1);
    check("d2_jump_addr", bus2.imem_addr, exp_q2.pop_front());
`ifdef PERF_CNT_EN
    check("d2_perf_retired", perf_retired2, 32'd1);
    check("d2_perf_taken", perf_taken2, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch and PC sequencing stage directly upstream of the main decoder (opcode = instr_o[31:26]). Holds the 32-bit PC and fetches one instruction at a time over a valid/ready instruction-memory interface. Presents the instruction to decode/execute and waits for an execute-complete pulse. It then computes the next PC from the decoder's jump/beq/bne outputs and the ALU zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
ADDR_W, 32, PC/address width; fixed at 32 in this design, present for lint/documentation.

Ports:
clk  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  fetch address (= pc_o)
imem_rsp_valid  in  1  response data valid (single-cycle pulse)
imem_rsp_data  in  32  fetched instruction word
instr_o  out  32  held instruction to decoder
instr_valid  out  1  instr_o valid, held until exec_done
pc_o  out  32  current PC
pc_plus4_o  out  32  pc_o + 4 (jal/link use)
exec_done  in  1  execute finished current instruction; PC update this edge
jump  in  1  from decoder
beq  in  1  from decoder
bne  in  1  from decoder
alu_zero  in  1  ALU zero flag

Behaviour:
- Reset values: pc = RESET_PC, state = IDLE, imem_req_valid = 0, instr_valid = 0, instr_o = 0.
- FSM:
  - IDLE: next cycle goes to REQ unconditionally.
  - REQ: imem_req_valid = 1 and imem_addr = pc. Goes to WAIT on imem_req_valid & imem_req_ready.
  - WAIT: on imem_rsp_valid, latch instr_o = imem_rsp_data and go to HOLD.
  - HOLD: instr_valid = 1. On exec_done, pc <= next_pc and go to REQ.
- Latency: best case is 3 cycles from request to instr_valid: REQ accept, then WAIT response, then HOLD. Response may arrive the cycle after acceptance or later; no timeout.
- imem_rsp_valid outside WAIT is ignored. This also drops stale responses after reset.
- exec_done outside HOLD is ignored and does not change the PC.
- next_pc, combinational from instr_o and pc, 32-bit wrap-around arithmetic:
  - pc_plus4 = pc + 4; 32'hFFFF_FFFC + 4 wraps to 0.
  - br_target = pc_plus4 + (sign_extend(instr_o[15:0]) << 2).
  - j_target = {pc_plus4[31:28], instr_o[25:0], 2'b00}.
- next_pc priority:
  - jump → j_target.
  - else beq & alu_zero → br_target.
  - else bne & ~alu_zero → br_target.
  - else pc_plus4.
- beq and bne both asserted is an illegal decoder output; treat it as not-taken (pc_plus4).
- pc[1:0] is forced to 00 on every load.
- Reset mid-operation (any state, including WAIT with an outstanding request) returns to IDLE with pc = RESET_PC on the next edge. Reset has priority over exec_done.
- imem_req_valid stays high in REQ until accepted. imem_addr must be stable while imem_req_valid = 1.

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs perf_retired (32 bits) and perf_taken (32 bits), both reset to 0.
  - perf_retired increments on every HOLD & exec_done.
  - perf_taken increments when that PC update selects j_target or br_target.
  - Both wrap silently at 2^32.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg: fetch state enum (IDLE, REQ, WAIT, HOLD), INSTR_W = 32, NOP_INSTR = 32'h0, opcode field position constants.
- One sub-module, next_pc_calc: purely combinational target computation and priority select, so it can be unit-tested in isolation.

Test Plan:
1. Reset with RESET_PC = 0, memory always ready, 1-cycle response → first request addr 0x0000_0000. instr_valid rises 3 cycles after reset deassert. exec_done with no branch → next addr 0x0000_0004.
2. pc = 0x0000_0010, instr imm = 0x0003, beq = 1, alu_zero = 1, exec_done → next addr 0x0000_0020. Same with alu_zero = 0 → 0x0000_0014.
3. pc = 0x0000_0040, imm = 0xFFFE, bne = 1, alu_zero = 0 → next addr 0x0000_003C (backward branch).
4. pc = 0x4000_0000, instr[25:0] = 0x000_0100, jump = 1 with beq = 1 also set → next addr 0x4000_0400 (jump priority).
5. Handshake stress: imem_req_ready low 4 cycles, response delayed 5 cycles, spurious imem_rsp_valid in HOLD → imem_addr stable throughout, instr_o unchanged by the spurious pulse. Reset asserted in WAIT → IDLE, pc = RESET_PC, late response ignored.
6. PERF_CNT_EN defined: retire 5 instructions, 2 taken → perf_retired = 5, perf_taken = 2. pc = 0xFFFF_FFFC fall-through wraps to 0x0000_0000.
